dram_req_ctrl: RTL
==================

# dram_req_ctrl

Memory-stage request sequencer between the pipeline's load/store issue and the DRAM bus. Accepts one load or store per transaction, aligns store data and byte strobes, drives a valid/ready request to DRAM, waits for read data, and presents the raw 32-bit word, the byte address and the load type to the downstream load-data formatter. That formatter performs byte/half extraction and sign extension. Single outstanding transaction; the pipeline stalls on `req_ready` low.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles in WAIT_R before an error response is returned.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: pipeline request present.
- `req_ready` out 1: controller idle; request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_load_type` in 5: one-hot {lhu, lbu, lw, lh, lb}, passed through for loads.
- `mem_valid` out 1: bus request valid.
- `mem_ready` in 1: bus accepts the request.
- `mem_we` out 1: write request.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2], 2'b00}`.
- `mem_wdata` out 32: store data shifted left by `req_addr[1:0]*8`.
- `mem_wstrb` out 4: byte enables; 0 for reads.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: captured raw word; 0 for stores and errors.
- `resp_raddr` out 32: original byte address.
- `resp_load_type` out 5: captured load type; 0 for stores.
- `resp_err` out 2: 0 = ok, 1 = misaligned, 2 = timeout.

## Operation
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE: `req_ready`=1. On accept, latch all request fields.
  - Misaligned requests (half with `addr[0]`=1; word with `addr[1:0]`≠0; any size 3) -> RESP with `resp_err`=1, no bus activity.
  - Otherwise -> REQ.
- REQ: `mem_valid`=1, with `mem_*` stable until `mem_ready`.
  - On `mem_ready`: store -> RESP; load -> WAIT_R, timeout counter cleared.
- WAIT_R: on `mem_rvalid`, capture `mem_rdata` -> RESP.
  - Counter increments every cycle. On reaching `TIMEOUT_CYCLES` without `mem_rvalid` -> RESP with `resp_err`=2 and `resp_rdata`=0.
- RESP: `resp_valid`=1 for exactly one cycle -> IDLE.
- Strobes: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111`.
- `mem_rvalid` outside WAIT_R is ignored. `mem_ready` outside REQ is ignored.
- Timeout counter width: `$clog2(TIMEOUT_CYCLES+1)`, saturating.

## Timing
- Reset values: state IDLE, `req_ready`=1. All other outputs 0: `mem_valid`, `mem_we`, `mem_wstrb`, `mem_addr`, `mem_wdata`, `resp_*`.
- Reset mid-transaction returns to IDLE asynchronously, drops `mem_valid` immediately, and emits no response. Read data arriving after reset is ignored.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Load latency, zero-wait bus: accept at T0, `mem_valid` at T1, `mem_ready` at T1, `mem_rvalid` at T2, `resp_valid` at T3.
- Store latency: accept at T0, `mem_valid`/`mem_ready` at T1, `resp_valid` at T2.
- Misaligned: accept at T0, `resp_valid` at T1.
- Back-to-back: next accept no earlier than the cycle after `resp_valid`. Sustained throughput is one transaction per 3 cycles for stores and 4 cycles for loads.

## Structure
- Package `dram_pkg` holds:
  - state enum;
  - size codes `SZ_B`/`SZ_H`/`SZ_W`;
  - load-type bit indices;
  - `resp_err` codes.
- Sub-module `dram_wstrb_gen` (combinational): from size, `addr[1:0]` and wdata, produces `wstrb`, shifted wdata and the misalign flag.
- Top module contains the FSM, request latch, timeout counter and response registers.

## Test plan
- Load word: addr 0x80000004, lw, `mem_rdata` 0xDEADBEEF, zero-wait -> `resp_valid` at T3 with rdata 0xDEADBEEF, raddr 0x80000004, err 0.
- Store byte: addr 0x80000013, wdata 0x000000A5 -> `mem_addr` 0x80000010, wstrb 4'b1000, wdata 0xA5000000, `resp_valid` at T2.
- Misaligned half: addr 0x80000001, size 1 -> `resp_valid` at T1 with err 1; `mem_valid` never asserted.
- Bus backpressure: `mem_ready` held low 5 cycles -> `mem_valid` and all `mem_*` stable across all 5 cycles; completion shifts by 5.
- Timeout: `TIMEOUT_CYCLES`=8, `mem_rvalid` never asserted -> `resp_valid` with err 2 and rdata 0 after 8 cycles in WAIT_R. A late `mem_rvalid` afterwards is ignored.
- Reset in WAIT_R: `rst` pulse -> outputs return to reset values without a clock edge; a subsequent `mem_rvalid` produces no `resp_valid`.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and codes for the DRAM request sequencer.
package dram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Bit positions inside the one-hot load type {lhu, lbu, lw, lh, lb}.
    localparam int LT_LB  = 0;
    localparam int LT_LH  = 1;
    localparam int LT_LW  = 2;
    localparam int LT_LBU = 3;
    localparam int LT_LHU = 4;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/dram_wstrb_gen.sv
// Store lane alignment: byte strobes, shifted write data and the misalign flag.
module dram_wstrb_gen
    import dram_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        o_wstrb    = 4'b0000;
        o_misalign = 1'b0;
        case (i_size)
            SZ_B: o_wstrb = 4'b0001 << i_addr_lo;
            SZ_H: begin
                o_wstrb    = 4'b0011 << i_addr_lo;
                o_misalign = i_addr_lo[0];
            end
            SZ_W: begin
                o_wstrb    = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: o_misalign = 1'b1;
        endcase
    end

    assign o_wdata = i_wdata << {i_addr_lo, 3'b000};

endmodule

// File: rtl/dram_req_ctrl.sv
// Single-outstanding load/store sequencer from the memory stage to the DRAM bus.
//
// state     | meaning
// ST_IDLE   | ready for a pipeline request
// ST_REQ    | bus request held until mem_ready
// ST_WAIT_R | load issued, waiting for read data or timeout
// ST_RESP   | one-cycle completion pulse
module dram_req_ctrl
    import dram_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic [4:0]  req_load_type,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] resp_raddr,
    output logic [4:0]  resp_load_type,
    output logic [1:0]  resp_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic [31:0]      r_rdata;
    logic [31:0]      r_raddr;
    logic [4:0]       r_load_type;
    logic [1:0]       r_err;

    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata;
    logic             w_misalign;
    logic             w_accept;
    logic             w_cnt_tc;

    dram_wstrb_gen u_wstrb_gen (
        .i_size     (req_size),
        .i_addr_lo  (req_addr[1:0]),
        .i_wdata    (req_wdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_cnt_tc = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next = w_misalign ? ST_RESP : ST_REQ;
            ST_REQ:    if (mem_ready) w_next = r_we ? ST_RESP : ST_WAIT_R;
            ST_WAIT_R: if (mem_rvalid || w_cnt_tc) w_next = ST_RESP;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
            r_raddr     <= '0;
            r_load_type <= '0;
            r_err       <= ERR_OK;
        end else begin
            if (w_accept) begin
                r_we        <= req_we;
                r_addr      <= {req_addr[31:2], 2'b00};
                r_wdata     <= req_we ? w_wdata : 32'h0;
                r_wstrb     <= req_we ? w_wstrb : 4'b0000;
                r_rdata     <= '0;
                r_raddr     <= req_addr;
                r_load_type <= req_we ? 5'b00000 : req_load_type;
                r_err       <= w_misalign ? ERR_MISALIGN : ERR_OK;
            end
            if (r_state == ST_REQ && mem_ready) r_cnt <= '0;
            // Read data wins over a timeout landing in the same cycle.
            if (r_state == ST_WAIT_R) begin
                if (mem_rvalid)    r_rdata <= mem_rdata;
                else if (w_cnt_tc) r_err   <= ERR_TIMEOUT;
                else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign mem_valid      = (r_state == ST_REQ);
    assign resp_valid     = (r_state == ST_RESP);
    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign mem_wstrb      = r_wstrb;
    assign resp_rdata     = r_rdata;
    assign resp_raddr     = r_raddr;
    assign resp_load_type = r_load_type;
    assign resp_err       = r_err;

endmodule
